// File: rtl/pcie_ts_os_decoder.sv
// Per-lane receive TS1/TS2 ordered-set and idle-symbol decoder for 8b/10b PCIe links.
// Optional macro TS_CONSEC_CNT_EN adds ts_consec_o (count of identical consecutive TSs).
module pcie_ts_os_decoder #(
  parameter int MAX_NUM_LANES = 4,
  parameter int IDLE_COUNT    = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [MAX_NUM_LANES*8-1:0] rx_data_i,
  input  logic [MAX_NUM_LANES-1:0]   rx_datak_i,
  input  logic [MAX_NUM_LANES-1:0]   rx_valid_i,
  output logic [MAX_NUM_LANES-1:0]   ts1_valid_o,
  output logic [MAX_NUM_LANES-1:0]   ts2_valid_o,
  output logic [MAX_NUM_LANES-1:0]   idle_valid_o,
  output logic [MAX_NUM_LANES*8-1:0] link_num_o,
  output logic [MAX_NUM_LANES*8-1:0] lane_num_o,
  output logic [MAX_NUM_LANES*8-1:0] n_fts_o,
  output logic [MAX_NUM_LANES*8-1:0] rate_id_o,
  output logic [MAX_NUM_LANES*8-1:0] training_ctrl_o
`ifdef TS_CONSEC_CNT_EN
  ,
  output logic [MAX_NUM_LANES*4-1:0] ts_consec_o
`endif
);

  localparam int IW = $clog2(IDLE_COUNT + 1);
  localparam logic [7:0] COM_SYM  = 8'hBC;
  localparam logic [7:0] PAD_SYM  = 8'hF7;
  localparam logic [7:0] TS1_ID   = 8'h4A;
  localparam logic [7:0] TS2_ID   = 8'h45;
  localparam logic [7:0] IDLE_SYM = 8'h00;

  typedef enum logic [1:0] {HUNT = 2'd0, FIELDS = 2'd1, IDENT = 2'd2} state_e;

  for (genvar n = 0; n < MAX_NUM_LANES; n++) begin : g_lane
    logic [7:0]      sym_s;
    logic            k_s;
    logic            v_s;
    state_e          state_r;
    state_e          state_nxt_s;
    logic [3:0]      cnt_r;
    logic [3:0]      cnt_nxt_s;
    logic            is_com_s;
    logic            field_ok_s;
    logic            capture_s;
    logic            ident_cap_s;
    logic            commit_s;
    logic [2:0]      fidx_s;
    logic [4:0][7:0] shadow_r;
    logic [7:0]      ident_r;
    logic            ts1_r;
    logic            ts2_r;
    logic [7:0]      link_r;
    logic [7:0]      lane_r;
    logic [7:0]      nfts_r;
    logic [7:0]      rate_r;
    logic [7:0]      ctrl_r;
    logic [IW-1:0]   idle_cnt_r;
    logic [IW-1:0]   idle_cnt_nxt_s;
    logic            idle_valid_r;

    assign sym_s      = rx_data_i[8*n +: 8];
    assign k_s        = rx_datak_i[n];
    assign v_s        = rx_valid_i[n];
    assign is_com_s   = k_s && (sym_s == COM_SYM);
    // Link and lane number may be PAD (a K-character); all other fields are data.
    assign field_ok_s = (cnt_r <= 4'd2) ? (!k_s || (sym_s == PAD_SYM)) : !k_s;
    assign fidx_s     = cnt_r[2:0] - 3'd1;

    // Framing FSM next state; a COM anywhere restarts field collection
    always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      capture_s   = 1'b0;
      ident_cap_s = 1'b0;
      commit_s    = 1'b0;
      if (v_s) begin
        case (state_r)
          HUNT: begin
            if (is_com_s) begin
              state_nxt_s = FIELDS;
              cnt_nxt_s   = 4'd1;
            end else begin
              state_nxt_s = HUNT;
              cnt_nxt_s   = 4'd0;
            end
          end
          FIELDS: begin
            if (is_com_s) begin
              state_nxt_s = FIELDS;
              cnt_nxt_s   = 4'd1;
            end else if (field_ok_s) begin
              capture_s = 1'b1;
              if (cnt_r == 4'd5) begin
                state_nxt_s = IDENT;
                cnt_nxt_s   = 4'd6;
              end else begin
                cnt_nxt_s = cnt_r + 4'd1;
              end
            end else begin
              state_nxt_s = HUNT;
              cnt_nxt_s   = 4'd0;
            end
          end
          IDENT: begin
            if (is_com_s) begin
              state_nxt_s = FIELDS;
              cnt_nxt_s   = 4'd1;
            end else if (cnt_r == 4'd6) begin
              if (!k_s && ((sym_s == TS1_ID) || (sym_s == TS2_ID))) begin
                ident_cap_s = 1'b1;
                cnt_nxt_s   = 4'd7;
              end else begin
                state_nxt_s = HUNT;
                cnt_nxt_s   = 4'd0;
              end
            end else if (!k_s && (sym_s == ident_r)) begin
              if (cnt_r == 4'd15) begin
                state_nxt_s = HUNT;
                cnt_nxt_s   = 4'd0;
                commit_s    = 1'b1;
              end else begin
                cnt_nxt_s = cnt_r + 4'd1;
              end
            end else begin
              state_nxt_s = HUNT;
              cnt_nxt_s   = 4'd0;
            end
          end
          default: begin
            state_nxt_s = HUNT;
            cnt_nxt_s   = 4'd0;
          end
        endcase
      end else begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
      end
    end

    // Framing FSM state and symbol counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_r <= HUNT;
        cnt_r   <= 4'd0;
      end else begin
        state_r <= state_nxt_s;
        cnt_r   <= cnt_nxt_s;
      end
    end

    // Shadow capture, commit of fields and one-cycle TS pulses
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        shadow_r <= '0;
        ident_r  <= 8'h00;
        ts1_r    <= 1'b0;
        ts2_r    <= 1'b0;
        link_r   <= 8'h00;
        lane_r   <= 8'h00;
        nfts_r   <= 8'h00;
        rate_r   <= 8'h00;
        ctrl_r   <= 8'h00;
      end else begin
        if (capture_s) shadow_r[fidx_s] <= sym_s;
        if (ident_cap_s) ident_r <= sym_s;
        ts1_r <= commit_s && (ident_r == TS1_ID);
        ts2_r <= commit_s && (ident_r == TS2_ID);
        if (commit_s) begin
          link_r <= shadow_r[0];
          lane_r <= shadow_r[1];
          nfts_r <= shadow_r[2];
          rate_r <= shadow_r[3];
          ctrl_r <= shadow_r[4];
        end
      end
    end

    // Saturating run length of idle data symbols; invalid cycles hold the count
    always_comb begin
      idle_cnt_nxt_s = idle_cnt_r;
      if (v_s) begin
        if (!k_s && (sym_s == IDLE_SYM)) begin
          if (idle_cnt_r == IW'(IDLE_COUNT)) begin
            idle_cnt_nxt_s = idle_cnt_r;
          end else begin
            idle_cnt_nxt_s = idle_cnt_r + IW'(1);
          end
        end else begin
          idle_cnt_nxt_s = '0;
        end
      end else begin
        idle_cnt_nxt_s = idle_cnt_r;
      end
    end

    // Idle counter and registered idle indication
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        idle_cnt_r   <= '0;
        idle_valid_r <= 1'b0;
      end else begin
        idle_cnt_r   <= idle_cnt_nxt_s;
        idle_valid_r <= (idle_cnt_nxt_s == IW'(IDLE_COUNT));
      end
    end

    assign ts1_valid_o[n]          = ts1_r;
    assign ts2_valid_o[n]          = ts2_r;
    assign idle_valid_o[n]         = idle_valid_r;
    assign link_num_o[8*n +: 8]      = link_r;
    assign lane_num_o[8*n +: 8]      = lane_r;
    assign n_fts_o[8*n +: 8]         = nfts_r;
    assign rate_id_o[8*n +: 8]       = rate_r;
    assign training_ctrl_o[8*n +: 8] = ctrl_r;

`ifdef TS_CONSEC_CNT_EN
    logic [3:0] consec_r;
    logic [7:0] last_ident_r;
    logic       same_s;
    logic       hunt_abort_s;

    assign same_s       = (ident_r == last_ident_r) &&
                          (shadow_r == {ctrl_r, rate_r, nfts_r, lane_r, link_r});
    assign hunt_abort_s = v_s && (state_r != HUNT) && (state_nxt_s == HUNT) && !commit_s;

    // Consecutive identical-TS counter, updated alongside the commit
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        consec_r     <= 4'd0;
        last_ident_r <= 8'h00;
      end else if (commit_s) begin
        last_ident_r <= ident_r;
        if (same_s) begin
          consec_r <= (consec_r == 4'd15) ? 4'd15 : consec_r + 4'd1;
        end else begin
          consec_r <= 4'd1;
        end
      end else if (hunt_abort_s) begin
        consec_r <= 4'd0;
      end else begin
        consec_r <= consec_r;
      end
    end

    assign ts_consec_o[4*n +: 4] = consec_r;
`endif
  end

endmodule

// File: tb/tb_pcie_ts_os_decoder.sv
// Self-checking bench for pcie_ts_os_decoder: directed test-plan steps followed by
// randomized per-lane traffic, checked every cycle against a symbol-history reference model.
module tb_pcie_ts_os_decoder;

  localparam int L  = 4;
  localparam int IC = 8;
  localparam int FD = 256;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [L*8-1:0] rx_data_i;
  logic [L-1:0]   rx_datak_i;
  logic [L-1:0]   rx_valid_i;
  logic [L-1:0]   ts1_valid_o;
  logic [L-1:0]   ts2_valid_o;
  logic [L-1:0]   idle_valid_o;
  logic [L*8-1:0] link_num_o;
  logic [L*8-1:0] lane_num_o;
  logic [L*8-1:0] n_fts_o;
  logic [L*8-1:0] rate_id_o;
  logic [L*8-1:0] training_ctrl_o;
`ifdef TS_CONSEC_CNT_EN
  logic [L*4-1:0] ts_consec_o;
`endif

  int errors = 0;
  int checks = 0;

  pcie_ts_os_decoder #(.MAX_NUM_LANES(L), .IDLE_COUNT(IC)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .rx_data_i      (rx_data_i),
    .rx_datak_i     (rx_datak_i),
    .rx_valid_i     (rx_valid_i),
    .ts1_valid_o    (ts1_valid_o),
    .ts2_valid_o    (ts2_valid_o),
    .idle_valid_o   (idle_valid_o),
    .link_num_o     (link_num_o),
    .lane_num_o     (lane_num_o),
    .n_fts_o        (n_fts_o),
    .rate_id_o      (rate_id_o),
    .training_ctrl_o(training_ctrl_o)
`ifdef TS_CONSEC_CNT_EN
    ,
    .ts_consec_o    (ts_consec_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Per-lane stimulus FIFOs, entry = {valid, k, data}
  logic [9:0] fifo [L][FD];
  int         head [L];
  int         tail [L];

  // Reference model: symbols since the last COM, plus the expected outputs
  logic [8:0] pre      [L][16];
  int         plen     [L];
  int         idle_run [L];
  logic [L-1:0] e_ts1, e_ts2, e_idle;
  logic [7:0] e_f      [L][5];
  logic [7:0] e_type   [L];
  logic [3:0] e_consec [L];
  int         pulses1  [L];
  int         pulses2  [L];

  // Last random TS parameters per lane, reused to create identical repeats
  logic       lp_ts2 [L];
  logic [8:0] lp_s1  [L];
  logic [8:0] lp_s2  [L];
  logic [7:0] lp_nf  [L];
  logic [7:0] lp_rt  [L];
  logic [7:0] lp_ct  [L];

  function automatic logic [8:0] dsym(input logic [7:0] d);
    return {1'b0, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // A prefix is well formed if every symbol so far obeys the TS layout rules.
  function automatic bit prefix_ok(input int l);
    bit ok = 1'b1;
    for (int i = 0; i < plen[l]; i++) begin
      logic k;
      logic [7:0] d;
      k = pre[l][i][8];
      d = pre[l][i][7:0];
      if (i == 0)      ok &= k && (d == 8'hBC);
      else if (i <= 2) ok &= !k || (d == 8'hF7);
      else if (i <= 5) ok &= !k;
      else if (i == 6) ok &= !k && ((d == 8'h4A) || (d == 8'h45));
      else             ok &= !k && (d == pre[l][6][7:0]);
    end
    return ok;
  endfunction

  task automatic model_reset();
    e_ts1 = '0; e_ts2 = '0; e_idle = '0;
    for (int l = 0; l < L; l++) begin
      plen[l] = 0; idle_run[l] = 0; e_type[l] = 8'h00; e_consec[l] = 4'd0;
      for (int i = 0; i < 5; i++) e_f[l][i] = 8'h00;
    end
  endtask

  task automatic model_update(input int l, input logic [9:0] e);
    bit same;
    e_ts1[l] = 1'b0;
    e_ts2[l] = 1'b0;
    if (e[9]) begin
      if (!e[8] && (e[7:0] == 8'h00)) idle_run[l]++;
      else idle_run[l] = 0;
      e_idle[l] = (idle_run[l] >= IC);
      if (e[8] && (e[7:0] == 8'hBC)) begin
        pre[l][0] = e[8:0];
        plen[l] = 1;
      end else if (plen[l] > 0) begin
        pre[l][plen[l]] = e[8:0];
        plen[l]++;
        if (!prefix_ok(l)) begin
          plen[l] = 0;
          e_consec[l] = 4'd0;
        end else if (plen[l] == 16) begin
          same = (pre[l][6][7:0] == e_type[l]);
          for (int i = 1; i <= 5; i++) same &= (pre[l][i][7:0] == e_f[l][i-1]);
          for (int i = 1; i <= 5; i++) e_f[l][i-1] = pre[l][i][7:0];
          e_type[l] = pre[l][6][7:0];
          e_ts1[l] = (e_type[l] == 8'h4A);
          e_ts2[l] = (e_type[l] == 8'h45);
          if (!same) e_consec[l] = 4'd1;
          else if (e_consec[l] != 4'd15) e_consec[l] = e_consec[l] + 4'd1;
          plen[l] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [L*8-1:0] xl, xn, xf, xr, xc;
    logic [L*4-1:0] xs;
    for (int l = 0; l < L; l++) begin
      xl[8*l +: 8] = e_f[l][0];
      xn[8*l +: 8] = e_f[l][1];
      xf[8*l +: 8] = e_f[l][2];
      xr[8*l +: 8] = e_f[l][3];
      xc[8*l +: 8] = e_f[l][4];
      xs[4*l +: 4] = e_consec[l];
      pulses1[l] += int'(ts1_valid_o[l]);
      pulses2[l] += int'(ts2_valid_o[l]);
    end
    check("ts1_valid", 32'(ts1_valid_o), 32'(e_ts1));
    check("ts2_valid", 32'(ts2_valid_o), 32'(e_ts2));
    check("idle_valid", 32'(idle_valid_o), 32'(e_idle));
    check("link_num", link_num_o, xl);
    check("lane_num", lane_num_o, xn);
    check("n_fts", n_fts_o, xf);
    check("rate_id", rate_id_o, xr);
    check("training_ctrl", training_ctrl_o, xc);
`ifdef TS_CONSEC_CNT_EN
    check("ts_consec", 32'(ts_consec_o), 32'(xs));
`else
    if (xs != xs) $display("unreachable");
`endif
  endtask

  task automatic push(input int l, input logic [9:0] e);
    if (head[l] == tail[l]) begin
      head[l] = 0;
      tail[l] = 0;
    end
    if (tail[l] < FD) begin
      fifo[l][tail[l]] = e;
      tail[l]++;
    end
  endtask

  task automatic push_ts(input int l, input bit ts2, input logic [8:0] s1, input logic [8:0] s2,
                         input logic [7:0] nf, input logic [7:0] rt, input logic [7:0] ct,
                         input int n_syms, input int bad_idx, input logic [8:0] bad, input int gap_pct);
    logic [8:0] sym [16];
    sym[0] = {1'b1, 8'hBC};
    sym[1] = s1;
    sym[2] = s2;
    sym[3] = dsym(nf);
    sym[4] = dsym(rt);
    sym[5] = dsym(ct);
    for (int i = 6; i < 16; i++) sym[i] = dsym(ts2 ? 8'h45 : 8'h4A);
    if (bad_idx >= 0 && bad_idx < 16) sym[bad_idx] = bad;
    for (int i = 0; i < n_syms; i++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) push(l, 10'd0);
      push(l, {1'b1, sym[i]});
    end
  endtask

  function automatic int pending();
    int p = 0;
    for (int l = 0; l < L; l++) p += tail[l] - head[l];
    return p;
  endfunction

  task automatic step();
    logic [9:0] e;
    @(negedge clk_i);
    check_all();
    for (int l = 0; l < L; l++) begin
      if (head[l] != tail[l]) begin
        e = fifo[l][head[l]];
        head[l]++;
      end else begin
        e = 10'd0;
      end
      rx_valid_i[l]        = e[9];
      rx_datak_i[l]        = e[8];
      rx_data_i[8*l +: 8]  = e[7:0];
      model_update(l, e);
    end
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while (pending() != 0 && n < max_cyc) begin
      step();
      n++;
    end
    check("drain_pending", 32'(pending()), 32'd0);
    for (int l = 0; l < L; l++) head[l] = tail[l];
    step();
    step();
  endtask

  task automatic refill(input int l);
    int r;
    int bad_idx;
    logic [8:0] bad;
    logic [7:0] pick [6];
    r = $urandom_range(0, 9);
    if (r <= 4) begin
      if ($urandom_range(0, 1) == 0) begin
        lp_ts2[l] = 1'($urandom_range(0, 1));
        lp_s1[l]  = ($urandom_range(0, 3) == 0) ? {1'b1, 8'hF7} : dsym(8'($urandom_range(0, 255)));
        lp_s2[l]  = ($urandom_range(0, 3) == 0) ? {1'b1, 8'hF7} : dsym(8'($urandom_range(0, 255)));
        lp_nf[l]  = 8'($urandom_range(0, 255));
        lp_rt[l]  = 8'($urandom_range(0, 255));
        lp_ct[l]  = 8'($urandom_range(0, 255));
      end
      pick[0] = 8'($urandom_range(0, 255));
      pick[1] = 8'h4A; pick[2] = 8'h45; pick[3] = 8'hF7; pick[4] = 8'hBC; pick[5] = 8'h00;
      bad_idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : -1;
      bad = {1'($urandom_range(0, 1)), pick[$urandom_range(0, 5)]};
      push_ts(l, lp_ts2[l], lp_s1[l], lp_s2[l], lp_nf[l], lp_rt[l], lp_ct[l], 16, bad_idx, bad, 8);
    end else if (r <= 7) begin
      repeat ($urandom_range(1, 12)) push(l, {2'b10, 8'h00});
    end else if (r == 8) begin
      push(l, {1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255))});
    end else begin
      repeat ($urandom_range(1, 3)) push(l, 10'd0);
    end
  endtask

  initial begin
    int p1, p2;
    rst_i = 1'b1;
    rx_data_i = '0; rx_datak_i = '0; rx_valid_i = '0;
    for (int l = 0; l < L; l++) begin
      head[l] = 0; tail[l] = 0; pulses1[l] = 0; pulses2[l] = 0;
      lp_ts2[l] = 1'b0; lp_s1[l] = 9'd0; lp_s2[l] = 9'd0;
      lp_nf[l] = 8'h00; lp_rt[l] = 8'h00; lp_ct[l] = 8'h00;
    end
    model_reset();

    // Reset state
    step();
    step();
    rst_i = 1'b0;

    // Lane0 TS1 with explicit fields
    push_ts(0, 1'b0, dsym(8'h00), dsym(8'h02), 8'h80, 8'h02, 8'h00, 16, -1, 9'd0, 0);
    drain(100);
    check("t1_link0", 32'(link_num_o[7:0]), 32'h00);
    check("t1_lane0", 32'(lane_num_o[7:0]), 32'h02);
    check("t1_rate0", 32'(rate_id_o[7:0]), 32'h02);
    check("t1_pulses", 32'(pulses1[0]), 32'd1);

    // Lane1 TS2 with PAD link and lane numbers
    push_ts(1, 1'b1, {1'b1, 8'hF7}, {1'b1, 8'hF7}, 8'h1F, 8'h02, 8'h00, 16, -1, 9'd0, 0);
    drain(100);
    check("t2_link1", 32'(link_num_o[15:8]), 32'hF7);
    check("t2_pulses2", 32'(pulses2[1]), 32'd1);
    check("t2_pulses1", 32'(pulses1[1]), 32'd0);

    // Lane3 TS1 with a wrong identifier at sym9, then a clean TS1
    push_ts(3, 1'b0, dsym(8'h01), dsym(8'h03), 8'h10, 8'h02, 8'h00, 16, 9, dsym(8'h45), 0);
    drain(100);
    check("bad_id_pulses", 32'(pulses1[3]), 32'd0);
    check("bad_id_lane", 32'(lane_num_o[31:24]), 32'h00);
    push_ts(3, 1'b0, dsym(8'h05), dsym(8'h06), 8'h10, 8'h02, 8'h00, 16, -1, 9'd0, 0);
    drain(100);
    check("clean_pulses", 32'(pulses1[3]), 32'd1);
    check("clean_lane", 32'(lane_num_o[31:24]), 32'h06);

    // Lane0 COM at sym4 restarts into a full TS2
    p1 = pulses1[0];
    p2 = pulses2[0];
    push_ts(0, 1'b0, dsym(8'h11), dsym(8'h12), 8'h13, 8'h14, 8'h15, 4, -1, 9'd0, 0);
    push_ts(0, 1'b1, dsym(8'h21), dsym(8'h22), 8'h33, 8'h44, 8'h55, 16, -1, 9'd0, 0);
    drain(100);
    check("resync_ts2", 32'(pulses2[0] - p2), 32'd1);
    check("resync_ts1", 32'(pulses1[0] - p1), 32'd0);
    check("resync_link", 32'(link_num_o[7:0]), 32'h21);

    // Lane2 idle run broken after 7, then 8 idles with a 3-cycle valid gap
    repeat (7) push(2, {2'b10, 8'h00});
    push(2, {2'b10, 8'h01});
    repeat (4) push(2, {2'b10, 8'h00});
    repeat (3) push(2, 10'd0);
    repeat (3) push(2, {2'b10, 8'h00});
    drain(100);
    check("idle_before_8th", 32'(idle_valid_o[2]), 32'd0);
    push(2, {2'b10, 8'h00});
    step();
    step();
    check("idle_after_8th", 32'(idle_valid_o[2]), 32'd1);

    // Reset asserted in the middle of TSs on every lane
    for (int l = 0; l < L; l++)
      push_ts(l, 1'(l & 1), dsym(8'h31), dsym(8'h32), 8'h33, 8'h34, 8'h35, 16, -1, 9'd0, 0);
    repeat (9) step();
    #2 rst_i = 1'b1;
    #1;
    rx_valid_i = '0;
    model_reset();
    check_all();
    @(negedge clk_i);
    rst_i = 1'b0;
    drain(100);

`ifdef TS_CONSEC_CNT_EN
    // Eight identical back-to-back TS1s, then one with a different lane number
    p1 = pulses1[0];
    repeat (8) push_ts(0, 1'b0, dsym(8'h07), dsym(8'h01), 8'h80, 8'h02, 8'h00, 16, -1, 9'd0, 0);
    drain(200);
    check("consec8", 32'(ts_consec_o[3:0]), 32'd8);
    check("consec8_pulses", 32'(pulses1[0] - p1), 32'd8);
    push_ts(0, 1'b0, dsym(8'h07), dsym(8'h02), 8'h80, 8'h02, 8'h00, 16, -1, 9'd0, 0);
    drain(100);
    check("consec_diff", 32'(ts_consec_o[3:0]), 32'd1);
`endif

    // Randomized traffic on all lanes
    repeat (3000) begin
      for (int l = 0; l < L; l++)
        if (head[l] == tail[l]) refill(l);
      step();
    end
    drain(500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit exceeded");
  end

endmodule

// File: doc/pcie_ts_os_decoder.md
Name: pcie_ts_os_decoder

Overview:
- Per-lane receive-side TS1/TS2 ordered-set decoder for Gen1/Gen2 (8b/10b) links.
- Sits directly upstream of the LTSSM configuration substate block.
- Parses the descrambled, decoded symbol stream per lane and produces the TS-valid, idle-valid and field vectors that block consumes: link number, lane number, rate ID and training control.
- All lanes are decoded independently and in parallel, one symbol per lane per clock.

Parameters:
- MAX_NUM_LANES, 4, number of lanes decoded in parallel.
- IDLE_COUNT, 8, number of consecutive idle data symbols required for idle_valid.

Ports:
- clk_i  input  1  core clock.
- rst_i  input  1  reset; asynchronous, active-high.
- rx_data_i  input  MAX_NUM_LANES*8  received symbol per lane; lane n in bits [8n+7:8n].
- rx_datak_i  input  MAX_NUM_LANES  1 = symbol of lane n is a K-character.
- rx_valid_i  input  MAX_NUM_LANES  1 = symbol of lane n is valid this cycle.
- ts1_valid_o  output  MAX_NUM_LANES  one-cycle pulse: a complete well-formed TS1 was received on lane n.
- ts2_valid_o  output  MAX_NUM_LANES  one-cycle pulse: a complete well-formed TS2 was received on lane n.
- idle_valid_o  output  MAX_NUM_LANES  level: at least IDLE_COUNT consecutive idle data symbols on lane n.
- link_num_o  output  MAX_NUM_LANES*8  symbol 1 of the last valid TS (0xF7 = PAD).
- lane_num_o  output  MAX_NUM_LANES*8  symbol 2 of the last valid TS (0xF7 = PAD).
- n_fts_o  output  MAX_NUM_LANES*8  symbol 3 of the last valid TS.
- rate_id_o  output  MAX_NUM_LANES*8  symbol 4 of the last valid TS.
- training_ctrl_o  output  MAX_NUM_LANES*8  symbol 5 of the last valid TS.

Behaviour:
- Symbol constants:
  - COM = 0xBC with K=1.
  - PAD = 0xF7 with K=1.
  - TS1 identifier = 0x4A with K=0.
  - TS2 identifier = 0x45 with K=0.
  - Idle data symbol = 0x00 with K=0.
- TS layout:
  - sym0 = COM.
  - sym1 = link number: PAD, or data.
  - sym2 = lane number: PAD, or data.
  - sym3 = N_FTS, data.
  - sym4 = rate ID, data.
  - sym5 = training control, data.
  - sym6..15 = identifier, all equal, data.
- Reset: every output is 0; all lanes enter HUNT; symbol counters and idle counters are 0.
- Per-lane FSM, advancing only on cycles where rx_valid_i[n]=1 (the lane holds state when rx_valid_i[n]=0):
  - HUNT:
    - COM -> FIELDS, sym_cnt=1.
    - Anything else -> stay in HUNT.
  - FIELDS (sym_cnt 1..5):
    - sym1 and sym2 accept data, or K=1 with value PAD; sym3..5 require K=0.
    - Capture each symbol into a shadow register.
    - A disallowed K-character -> HUNT.
    - After sym5 -> IDENT, sym_cnt=6.
  - IDENT (sym_cnt 6..15):
    - sym6 must be 0x4A or 0x45 with K=0; it fixes the TS type.
    - sym7..15 must equal sym6 with K=0.
    - A mismatch -> HUNT.
    - After a matching sym15 -> HUNT and commit.
  - COM received in FIELDS or IDENT: resync. Discard the partial TS and go to FIELDS with sym_cnt=1.
- Commit:
  - Occurs on the clock edge that accepts a matching sym15.
  - Shadow fields copy to the field outputs.
  - ts1_valid_o[n] or ts2_valid_o[n] is high for exactly the next cycle.
  - Latency from sym15 to the pulse is 1 cycle.
  - Field outputs hold their value until the next commit; an aborted TS never changes them.
- Back-to-back TSs (COM immediately after sym15) are accepted with no dead cycle; each produces its own pulse.
- Idle detection, per lane, on valid symbols only:
  - Idle data symbol -> idle counter increments, saturating at IDLE_COUNT.
  - Any other valid symbol -> idle counter clears to 0.
  - idle_valid_o[n] = registered (counter == IDLE_COUNT); it asserts the cycle after the IDLE_COUNT-th idle symbol.
  - It deasserts the cycle after the first non-idle valid symbol.
- Lanes are fully independent; there is no cross-lane deskew in this block.
- Reset asserted mid-TS: outputs clear immediately (asynchronously); no pulse is produced for the interrupted TS.

Optional Feature:
- Macro: TS_CONSEC_CNT_EN.
- With the macro defined:
  - Adds output ts_consec_o, MAX_NUM_LANES*4: per-lane count of consecutive identical committed TSs, saturating at 15.
  - Identical means same type and the same sym1..5 as the previous commit.
  - On a commit with an identical TS: count+1. On a commit that differs: count=1.
  - A HUNT abort clears the count to 0.
  - The count updates in the same cycle as the ts*_valid_o pulse.
- Without the macro: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Lane0 TS1 with link=0x00, lane=0x02, N_FTS=0x80, rate=0x02, ctrl=0x00 -> ts1_valid_o[0] pulses 1 cycle after sym15; link_num_o[7:0]=0x00, lane_num_o[7:0]=0x02, rate_id_o[7:0]=0x02.
- Lane1 TS2 with link/lane=PAD (K) -> ts2_valid_o[1] pulses; link_num_o[15:8]=0xF7; ts1_valid_o stays 0.
- TS1 whose sym9 is 0x45 -> no pulse; fields unchanged; next clean TS1 decodes normally.
- COM injected at sym4, followed by a full TS2 -> only one ts2_valid_o pulse, carrying the new fields.
- Sequence of 7 zero symbols then 0x01, then 8 zero symbols, with rx_valid_i low for 3 cycles mid-run -> idle_valid_o[2] stays 0 after the 7; it asserts 1 cycle after the 8th zero; the rx_valid_i gaps do not reset the count.
- With TS_CONSEC_CNT_EN: 8 identical back-to-back TS1s -> ts_consec_o lane0 = 8 and 8 separate pulses; a 9th TS1 with a different lane number -> count = 1.
